fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the architectural PC and issues requests to an instruction memory using a request/valid handshake.
- Delivers each fetched instruction and its PC+4 to the IF/ID pipeline register through a one-entry output buffer.
- Accepts stalls (freeze) from the hazard logic and PC redirects (branch, jump, jr) resolved in ID.
- Discards wrong-path fetches itself, so the downstream side sees only valid instructions or bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- IMEM_AW, 32, width of imem_addr; the lower IMEM_AW bits of PC are driven.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- freeze  input  1  downstream stall; output buffer is held while high.
- redirect_valid  input  1  one-cycle pulse from ID: a control transfer is taken.
- redirect_sel  input  2  00 branch, 01 jump, 10 jr, 11 reserved (treated as branch).
- branch_target  input  32  branch target computed in ID.
- jmp_addr  input  26  instr[25:0] of the jump.
- jr_addr  input  32  register value for jr.
- imem_req  output  1  request valid.
- imem_addr  output  IMEM_AW  request address (= PC).
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr_valid  output  1  output buffer holds a valid instruction.
- instruction  output  32  buffered instruction.
- pc_plus4  output  32  PC of the buffered instruction + 4.
- misalign_err  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst high): pc=RESET_PC, state=FETCH, drop=0, instr_valid=0, instruction=0, pc_plus4=0, misalign_err=0. imem_req=0 while rst is high.
- Only one memory request is outstanding at a time. The output buffer is "blocked" when instr_valid && freeze.
- FETCH state:
  - imem_req = !blocked; imem_addr = pc.
  - If imem_req && imem_ready, go to WAIT.
- WAIT state:
  - imem_req=0.
  - On imem_rvalid with drop=0: instruction<=imem_rdata, pc_plus4<=pc+4, instr_valid<=1, pc<=pc+4, go to FETCH.
  - On imem_rvalid with drop=1: discard the data, drop<=0, go to FETCH.
- Output buffer:
  - Consumed when instr_valid && !freeze.
  - If consumed and no new data arrives, instr_valid<=0 next cycle.
  - While blocked, instruction and pc_plus4 hold stable.
- Timing: with imem_ready=1 and rvalid one cycle after the request, the request is issued in cycle N, rvalid arrives in N+1, and instr_valid is high in N+2. Steady-state throughput is one instruction per 2 cycles.
- Redirect (redirect_valid=1) overrides freeze and every other event in the same cycle:
  - Target by redirect_sel:
    - branch: branch_target.
    - jump: {pc[31:28], jmp_addr, 2'b00}, where pc is the current fetch PC.
    - jr: jr_addr.
  - pc<=target with bits [1:0] forced to 0.
  - instr_valid<=0 (wrong-path instruction flushed).
  - State is WAIT and rvalid is not present: drop<=1.
  - State is WAIT and rvalid is present: discard data, go to FETCH.
  - State is FETCH and the request is accepted this cycle: go to WAIT with drop<=1.
  - State is FETCH and no request is accepted: stay in FETCH; the next request uses the target.
- A second redirect while drop=1 updates pc only; drop stays 1 and exactly one response is still discarded.
- PC wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
- Reset asserted mid-request: any rvalid that arrives after reset is released is ignored unless the unit is in WAIT.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: a redirect whose target has bits [1:0] != 0 sets misalign_err<=1, which stays set until rst. The redirect is still taken with bits [1:0] cleared.
- Not defined: misalign_err is tied to 0 and the low bits are cleared silently.

Test Plan:
- Reset release, imem_ready=1, rvalid 1 cycle after the request, rdata=0x2001_0005 -> imem_addr=0x0 in cycle 1; instr_valid=1, instruction=0x2001_0005, pc_plus4=0x4 in cycle 3; next imem_addr=0x4.
- freeze held 3 cycles while instr_valid=1 -> instruction and pc_plus4 stable, imem_req=0; after freeze drops, the next request is issued the following cycle.
- Redirect branch_target=0x40 while in WAIT, rvalid 2 cycles later -> returned data discarded, instr_valid stays 0, next imem_addr=0x40.
- Jump: pc=0x1000_0008, jmp_addr=26'h10 -> next imem_addr=0x1000_0040. jr with jr_addr=0x0000_0123 -> imem_addr=0x120; misalign_err=1 only when FETCH_ALIGN_CHECK_EN is defined.
- Redirect in the same cycle as freeze=1 and instr_valid=1 -> instr_valid=0 next cycle, pc=target.
- rst asserted in WAIT -> immediately imem_req=0 and instr_valid=0; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem request at a time,
// buffers the returned instruction for IF/ID and squashes wrong-path responses after redirects.
// Optional build macro FETCH_ALIGN_CHECK_EN: when defined, a redirect to a non-word-aligned
// target sets the sticky misalign_err flag; otherwise misalign_err is tied low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_sel,
  input  logic [31:0]        branch_target,
  input  logic [25:0]        jmp_addr,
  input  logic [31:0]        jr_addr,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [31:0]        instruction,
  output logic [31:0]        pc_plus4,
  output logic               misalign_err
);

  typedef enum logic [0:0] {StFetch, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instruction_q, instruction_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  logic        blocked;
  logic        req_accept;
  logic [31:0] target_raw;
  logic [31:0] target_pc;
  logic [31:0] pc_inc;

  assign blocked    = instr_valid_q & freeze;
  // Request is masked during reset so the memory never sees a request from a half-reset unit.
  assign imem_req   = ~rst & (state_q == StFetch) & ~blocked;
  assign imem_addr  = pc_q[IMEM_AW-1:0];
  assign req_accept = imem_req & imem_ready;
  assign pc_inc     = pc_q + 32'd4;

  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign pc_plus4    = pc_plus4_q;

  // Redirect target selection; reserved encoding falls back to the branch target.
  always_comb begin
    case (redirect_sel)
      2'b01:   target_raw = {pc_q[31:28], jmp_addr, 2'b00};
      2'b10:   target_raw = jr_addr;
      default: target_raw = branch_target;
    endcase
  end

  assign target_pc = target_raw & 32'hFFFF_FFFC;

  // Next-state logic: redirect dominates; otherwise the fetch/wait handshake advances.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q & freeze;  // consumed unless held by freeze
    instruction_d = instruction_q;
    pc_plus4_d    = pc_plus4_q;

    if (redirect_valid) begin
      pc_d          = target_pc;
      instr_valid_d = 1'b0;
      if (state_q == StWait) begin
        if (imem_rvalid) begin
          // The in-flight response lands now and is thrown away here.
          state_d = StFetch;
          drop_d  = 1'b0;
        end else begin
          drop_d = 1'b1;
        end
      end else if (req_accept) begin
        // Request for the old PC is already out; squash its response.
        state_d = StWait;
        drop_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (req_accept) state_d = StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            state_d = StFetch;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              instruction_d = imem_rdata;
              pc_plus4_d    = pc_inc;
              instr_valid_d = 1'b1;
              pc_d          = pc_inc;
            end
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State and output-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instruction_q <= 32'h0;
      pc_plus4_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      pc_plus4_q    <= pc_plus4_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Sticky flag: any redirect whose raw target is not word aligned.
  always_comb begin
    misalign_d = misalign_q | (redirect_valid & (|target_raw[1:0]));
  end

  // Misalignment flag register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
